// File: rtl/cond_unit_pkg.sv
// Shared definitions for the conditional-execution / write-back stage.
package cond_unit_pkg;

  // ARM condition-field encodings; 4'hf behaves like AL.
  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'ha;
  localparam logic [3:0] CondLt = 4'hb;
  localparam logic [3:0] CondGt = 4'hc;
  localparam logic [3:0] CondLe = 4'hd;
  localparam logic [3:0] CondAl = 4'he;

  // Bit positions inside the NZCV nibble.
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  // Write-back sequencer: StHi is the second beat of a long multiply.
  typedef enum logic {StIdle, StHi} state_e;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU side bundle of the conditional-execution stage.
interface cond_unit_if;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS;
  logic        RegW;
  logic        MemW;
  logic        LongMul;
  logic [3:0]  Rd;
  logic [31:0] WDin;
  logic [3:0]  RdLo;
  logic [3:0]  RdHi;
  logic [31:0] Result1;
  logic [31:0] Result2;

  logic        PCSrc;
  logic        RegWrite;
  logic        MemWrite;
  logic [3:0]  WA3;
  logic [31:0] WD3;
  logic        Stall;
  logic [3:0]  Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, LongMul, Rd, WDin, RdLo, RdHi,
           Result1, Result2,
    input  PCSrc, RegWrite, MemWrite, WA3, WD3, Stall, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, LongMul, Rd, WDin, RdLo, RdHi,
           Result1, Result2,
    output PCSrc, RegWrite, MemWrite, WA3, WD3, Stall, Flags
  );
endinterface

// File: rtl/cond_eval.sv
// Combinational ARM condition check of a 4-bit condition field against NZCV.
module cond_eval
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;
  assign n = flags[FlagN];
  assign z = flags[FlagZ];
  assign c = flags[FlagC];
  assign v = flags[FlagV];

  // Decode the condition field; anything not listed (AL and 4'hf) is unconditional.
  always_comb begin
    condex = 1'b1;
    case (cond)
      CondEq:  condex = z;
      CondNe:  condex = ~z;
      CondCs:  condex = c;
      CondCc:  condex = ~c;
      CondMi:  condex = n;
      CondPl:  condex = ~n;
      CondVs:  condex = v;
      CondVc:  condex = ~v;
      CondHi:  condex = c & ~z;
      CondLs:  condex = ~c | z;
      CondGe:  condex = (n == v);
      CondLt:  condex = (n != v);
      CondGt:  condex = ~z & (n == v);
      CondLe:  condex = z | (n != v);
      default: condex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution and write-back sequencing stage: NZCV register, write gating,
// and two-beat register-file write of 64-bit long-multiply results.
module cond_unit
  import cond_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  cond_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] hi_word_q, hi_word_d;
  logic [3:0]  hi_idx_q, hi_idx_d;
  logic        condex;

  logic        pcsrc, regwrite, memwrite, stall;
  logic [3:0]  wa3;
  logic [31:0] wd3;

  // Condition is always judged against the registered flags.
  cond_eval u_cond_eval (
    .cond   (bus.Cond),
    .flags  (flags_q),
    .condex (condex)
  );

  // Next-state, flag update and gated write-back outputs.
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    hi_word_d = hi_word_q;
    hi_idx_d  = hi_idx_q;
    pcsrc     = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    stall     = 1'b0;
    wa3       = bus.Rd;
    wd3       = bus.WDin;

    unique case (state_q)
      StIdle: begin
        if (bus.FlagW[1] && condex) begin
          flags_d[FlagN] = bus.ALUFlags[FlagN];
          flags_d[FlagZ] = bus.ALUFlags[FlagZ];
        end
        if (bus.FlagW[0] && condex) begin
          flags_d[FlagC] = bus.ALUFlags[FlagC];
          flags_d[FlagV] = bus.ALUFlags[FlagV];
        end
        if (bus.LongMul) begin
          // Low word now, high word next cycle while fetch is held.
          if (bus.RegW && condex) begin
            regwrite  = 1'b1;
            wa3       = bus.RdLo;
            wd3       = bus.Result2;
            stall     = 1'b1;
            hi_word_d = bus.Result1;
            hi_idx_d  = bus.RdHi;
            state_d   = StHi;
          end
        end else begin
          pcsrc    = bus.PCS & condex;
          regwrite = bus.RegW & condex;
          memwrite = bus.MemW & condex;
        end
      end
      StHi: begin
        // Instruction inputs are the repeated long multiply; use only the latched beat.
        regwrite = 1'b1;
        wa3      = hi_idx_q;
        wd3      = hi_word_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (reset) begin
      pcsrc    = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      stall    = 1'b0;
    end
  end

  // State, flag register and latched high beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      flags_q   <= 4'b0000;
      hi_word_q <= 32'h0;
      hi_idx_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      hi_word_q <= hi_word_d;
      hi_idx_q  <= hi_idx_d;
    end
  end

  assign bus.PCSrc    = pcsrc;
  assign bus.RegWrite = regwrite;
  assign bus.MemWrite = memwrite;
  assign bus.WA3      = wa3;
  assign bus.WD3      = wd3;
  assign bus.Stall    = stall;
  assign bus.Flags    = flags_q;

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution and write-back sequencing stage directly downstream of the ALU in the single-cycle processor. Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. Gates register, memory and PC writes accordingly. Sequences 64-bit long-multiply results (UMULL/SMULL, high word on Result1, low word on Result2) into the single-write-port register file over two cycles, stalling fetch for one cycle.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 4.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Cond  in  4  instruction condition field (Instr[31:28])
- ALUFlags  in  4  {N,Z,C,V} from ALU, current instruction
- FlagW  in  2  [1] permits N,Z update; [0] permits C,V update
- PCS  in  1  decoder: instruction writes PC
- RegW  in  1  decoder: instruction writes register file
- MemW  in  1  decoder: instruction writes memory
- LongMul  in  1  decoder: instruction is UMULL/SMULL
- Rd  in  4  destination register, normal instructions
- WDin  in  32  normal write-back data (result mux output)
- RdLo, RdHi  in  4 each  long-multiply destination registers
- Result1  in  32  ALU product high word
- Result2  in  32  ALU product low word
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated memory write enable
- WA3  out  4  register-file write address
- WD3  out  32  register-file write data
- Stall  out  1  hold PC and instruction register this cycle
- Flags  out  4  current NZCV register contents

## Operation
- CondEx per ARM table: EQ 0000 Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1110 and 1111 → always true.
- CondEx uses the registered flags, never the same-cycle ALUFlags.
- Flag update in IDLE only: N,Z ← ALUFlags[3:2] when FlagW[1]&CondEx; C,V ← ALUFlags[1:0] when FlagW[0]&CondEx.
- States: IDLE, HI.
- IDLE, not long-multiply:
  - PCSrc=PCS&CondEx; RegWrite=RegW&CondEx; MemWrite=MemW&CondEx.
  - WA3=Rd; WD3=WDin; Stall=0.
- IDLE, LongMul&RegW&CondEx:
  - RegWrite=1; WA3=RdLo; WD3=Result2; Stall=1; PCSrc=0; MemWrite=0.
  - Latch Result1 and RdHi; next state HI.
- IDLE, LongMul with CondEx=0: no writes, no stall, stay IDLE.
- HI:
  - RegWrite=1; WA3=latched RdHi; WD3=latched high word; Stall=0; PCSrc=0; MemWrite=0.
  - No flag update; inputs ignored (instruction is the repeated one); next state IDLE.
- RdLo==RdHi: both beats write; the high word, written last, wins.

## Timing
- Reset values: Flags=0000, state IDLE, latched word and index 0.
- While reset is asserted, PCSrc, RegWrite, MemWrite and Stall are forced 0.
- Normal instructions: gating is combinational, zero latency. Flag register updates on the next rising edge.
- Long multiply: 2 cycles, low write in cycle 1, high write in cycle 2. Stall is high only in cycle 1.
- Reset during HI: return to IDLE immediately; the pending high write is dropped.
- An S-suffixed long multiply updates flags exactly once, in cycle 1.

## Structure
- Shared package holds:
  - condition-code constants (EQ..AL);
  - NZCV bit indices (N=3, Z=2, C=1, V=0);
  - state enum {IDLE, HI}.
- Sub-module cond_eval: purely combinational, (Cond, Flags) → CondEx. Reused by any future pipelined variant.
- Flag register and sequencer FSM live in cond_unit.

## Test plan
- Reset, then Cond=0000 (EQ), RegW=1, Rd=3, WDin=0x55 → RegWrite=0 (Z=0). Then CMP with ALUFlags=0100, FlagW=11 → Flags=0100 next cycle; retry EQ → RegWrite=1, WA3=3, WD3=0x55.
- Flags=1000, Cond=1011 (LT) → CondEx=1; Flags=1001 → LT false, MemWrite=0 with MemW=1.
- UMULL, Cond=1110, Result1=0x00000001, Result2=0xFFFFFFFE, RdLo=4, RdHi=5:
  - cycle 1: WA3=4, WD3=0xFFFFFFFE, Stall=1;
  - cycle 2: WA3=5, WD3=0x00000001, Stall=0;
  - cycle 3: IDLE.
- SMULL with Cond=0001 (NE) while Z=1 → no RegWrite, Stall=0, state stays IDLE.
- Reset asserted asynchronously in HI → outputs 0 immediately, IDLE after release, no write of the high word.
- SMULLS, FlagW=10, ALUFlags=1000 → Flags N=1 after cycle 1. Change ALUFlags=0100 during cycle 2 → Flags unchanged.
